sparrow_lsu: RTL

//  Load/store unit of the memory stage. Consumes the memory controls produced by the decoder
//  (dmem_req, dmem_wr_en, dmem_byte_en, dmem_zero_extend) together with the ALU address and rs2 data.

---
 rtl/sparrow_pkg.sv | 31 +++
 rtl/sparrow_lsu_align.sv | 54 +++++
 rtl/sparrow_lsu.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sparrow_pkg.sv
// rtl/sparrow_pkg.sv - shared types for the sparrow core: byte-enable encoding and LSU states
package sparrow_pkg;

  // Access size encoding, shared with the decoder's dmem_byte_en output
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } byte_en_t;

  // Load/store unit state machine
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10,
    DONE     = 2'b11
  } lsu_state_e;

  // Halfwords need an even address, words a 4-byte aligned one; bytes are always fine
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (byte_en_t'(size))
      BYTE:      bad = 1'b0;
      HALF_WORD: bad = offset[0];
      default:   bad = |offset;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sparrow_lsu_align.sv
// rtl/sparrow_lsu_align.sv - store lane steering and load lane extraction/extension
module sparrow_lsu_align
  import sparrow_pkg::*;
(
  input  logic [1:0]  byte_en,
  input  logic [1:0]  offset,
  input  logic [31:0] wr_data,
  input  logic [1:0]  ld_byte_en,
  input  logic [1:0]  ld_offset,
  input  logic        ld_zero_extend,
  input  logic [31:0] rd_word,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rd_data
);

  logic [31:0] shifted;

  // Store side: lane strobes from size/offset, data replicated so every lane carries it
  always_comb begin
    misaligned = is_misaligned(byte_en, offset);
    be         = 4'b1111;
    wdata      = wr_data;
    case (byte_en_t'(byte_en))
      BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{wr_data[7:0]}};
      end
      HALF_WORD: begin
        be    = 4'b0011 << offset;
        wdata = {2{wr_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = wr_data;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend
  always_comb begin
    shifted = rd_word >> {ld_offset, 3'b000};
    rd_data = rd_word;
    case (byte_en_t'(ld_byte_en))
      BYTE:      rd_data = ld_zero_extend ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      HALF_WORD: rd_data = ld_zero_extend ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default:   rd_data = rd_word;
    endcase
  end

endmodule

// File: rtl/sparrow_lsu.sv
// rtl/sparrow_lsu.sv - memory-stage load/store unit with req/gnt/rvalid port and timeout
module sparrow_lsu
  import sparrow_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_wr_en,
  input  logic [1:0]  i_byte_en,
  input  logic        i_zero_extend,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rd_data,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state;
  logic [7:0]  cnt;
  logic [1:0]  ld_byte_en;
  logic [1:0]  ld_offset;
  logic        ld_zext;

  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_data;

  sparrow_lsu_align u_align (
    .byte_en        (i_byte_en),
    .offset         (i_addr[1:0]),
    .wr_data        (i_wr_data),
    .ld_byte_en     (ld_byte_en),
    .ld_offset      (ld_offset),
    .ld_zero_extend (ld_zext),
    .rd_word        (i_dmem_rdata),
    .misaligned     (misaligned),
    .be             (be),
    .wdata          (wdata),
    .rd_data        (ld_data)
  );

  // Hold the pipeline for any accepted access until the DONE cycle lets it advance
  assign o_stall = i_valid & ~misaligned & (state != DONE);

  // Access sequencer: captures the request, drives the bus, and times out stuck transfers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= 8'h0;
      ld_byte_en   <= 2'b00;
      ld_offset    <= 2'b00;
      ld_zext      <= 1'b0;
      o_done       <= 1'b0;
      o_rd_data    <= 32'h0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= 32'h0;
      o_dmem_be    <= 4'h0;
      o_dmem_wdata <= 32'h0;
    end else begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (misaligned) begin
              o_misaligned <= 1'b1;
            end else begin
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= i_wr_en;
              o_dmem_addr  <= {i_addr[31:2], 2'b00};
              o_dmem_be    <= be;
              o_dmem_wdata <= wdata;
              ld_byte_en   <= i_byte_en;
              ld_offset    <= i_addr[1:0];
              ld_zext      <= i_zero_extend;
              cnt          <= 8'h0;
              state        <= REQ;
            end
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            cnt        <= 8'h0;
            if (o_dmem_we) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= WAIT_RSP;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            o_dmem_req <= 1'b0;
            o_bus_err  <= 1'b1;
            cnt        <= 8'h0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        WAIT_RSP: begin
          if (i_dmem_rvalid) begin
            o_rd_data <= ld_data;
            o_done    <= 1'b1;
            state     <= DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            o_bus_err <= 1'b1;
            cnt       <= 8'h0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
